// File: rtl/rr_sel_arbiter.sv
// ---------------------------------------------------------------------------
// rr_sel_arbiter
//
// Round-robin arbiter for four requesters. It produces the 2-bit select for
// the downstream 4:1 mux plus a grant-valid flag that qualifies the mux
// output. An owner keeps the grant while it keeps requesting. If another
// channel is waiting, the owner is forced to rotate after MAX_HOLD cycles.
// MAX_HOLD = 0 means an owner is never forced to rotate.
//
// Ports
//   clk        : single rising-edge clock
//   rst_n      : asynchronous active-low reset
//   req[3:0]   : request lines, req[k]=1 -> channel k wants the mux
//   sel[1:0]   : index of the current (or most recent) owner -> mux select
//   gnt[3:0]   : one-hot grant, (1<<sel) while gnt_valid, else 0
//   gnt_valid  : 1 while a channel owns the mux
//   hold_cnt   : cycles the current owner has held the grant (saturating)
//
// All outputs are registered. A request is granted on the next clock edge.
// ---------------------------------------------------------------------------
module rr_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    output logic [1:0]        sel,
    output logic [3:0]        gnt,
    output logic              gnt_valid,
    output logic [HOLD_W-1:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Value at which an owner with competition must give up the grant.
    localparam logic [HOLD_W-1:0] HOLD_MAX_V = HOLD_W'(MAX_HOLD);
    // Saturation value of the counter.
    // With MAX_HOLD=0 the counter runs to all-ones and stays there.
    localparam logic [HOLD_W-1:0] HOLD_SAT_V =
        (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_MAX_V;

    state_t            state_reg,    state_next;
    logic [1:0]        last_ptr_reg, last_ptr_next;
    logic [1:0]        sel_reg,      sel_next;
    logic [3:0]        gnt_reg,      gnt_next;
    logic              gnt_valid_reg, gnt_valid_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    // -----------------------------------------------------------------------
    // Candidate search
    // -----------------------------------------------------------------------
    // The current owner is never a candidate for a new grant. In IDLE there
    // is no owner, so every requester is eligible. Channel last_ptr is then
    // visited last because the search starts just after it.
    logic [3:0] owner_mask;
    logic [3:0] cand_req;

    assign owner_mask = (state_reg == GRANT) ? (4'b0001 << sel_reg) : 4'b0000;
    assign cand_req   = req & ~owner_mask;

    // rot_req[k] is the candidate that sits k+1 places after last_ptr.
    // The first set bit of rot_req is therefore the round-robin winner.
    logic [1:0] rot_idx [4];
    logic [3:0] rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_idx[gi] = last_ptr_reg + 2'(gi + 1);
            assign rot_req[gi] = cand_req[rot_idx[gi]];
        end
    endgenerate

    logic       pick_found;
    logic [1:0] pick_off;
    logic [1:0] pick_idx;

    always_comb begin
        pick_found = |rot_req;
        pick_off   = 2'd0;
        // Scan downward so that the lowest offset, which is the nearest
        // channel in rotating order, is written last and wins.
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_off = 2'(i);
            end
        end
    end

    assign pick_idx = last_ptr_reg + pick_off + 2'd1;

    // -----------------------------------------------------------------------
    // Hold-time limit
    // -----------------------------------------------------------------------
    logic hold_expired;

    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_MAX_V);

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    logic grant_new;

    always_comb begin
        state_next     = state_reg;
        last_ptr_next  = last_ptr_reg;
        sel_next       = sel_reg;
        gnt_next       = gnt_reg;
        gnt_valid_next = gnt_valid_reg;
        hold_cnt_next  = hold_cnt_reg;
        grant_new      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_new = 1'b1;
                end
            end

            GRANT: begin
                if (!req[sel_reg]) begin
                    // Owner released. Hand over directly if anyone is
                    // waiting, so there is no idle bubble. Otherwise drop
                    // to IDLE and leave sel at its last value.
                    if (pick_found) begin
                        grant_new = 1'b1;
                    end else begin
                        state_next     = IDLE;
                        gnt_next       = 4'b0000;
                        gnt_valid_next = 1'b0;
                        hold_cnt_next  = '0;
                    end
                end else if (hold_expired && pick_found) begin
                    // The owner has used its full slot and another channel
                    // is waiting, so the grant is forced to rotate.
                    grant_new = 1'b1;
                end else if (hold_cnt_reg != HOLD_SAT_V) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (grant_new) begin
            state_next     = GRANT;
            sel_next       = pick_idx;
            last_ptr_next  = pick_idx;
            gnt_next       = 4'b0001 << pick_idx;
            gnt_valid_next = 1'b1;
            hold_cnt_next  = HOLD_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // last_ptr resets to 3 so that the first search after reset starts at
    // channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_ptr_reg  <= 2'd3;
            sel_reg       <= 2'd0;
            gnt_reg       <= 4'b0000;
            gnt_valid_reg <= 1'b0;
            hold_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            last_ptr_reg  <= last_ptr_next;
            sel_reg       <= sel_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= gnt_valid_next;
            hold_cnt_reg  <= hold_cnt_next;
        end
    end

    assign sel       = sel_reg;
    assign gnt       = gnt_reg;
    assign gnt_valid = gnt_valid_reg;
    assign hold_cnt  = hold_cnt_reg;

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Round-robin arbiter that produces the 2-bit select and a grant-valid flag for the downstream 4:1 mux data path.
- Four requesters raise req lines. The block picks one owner, drives sel to that owner's index, and holds the grant while the owner keeps requesting, subject to a maximum hold time.
- Sits directly upstream of the 4:1 mux: its sel output wires to the mux select, and gnt_valid qualifies the mux output y.

Parameters:
MAX_HOLD, 8, max consecutive cycles one owner may hold the grant while another channel is requesting; 0 = unlimited
HOLD_W, 4, width of the internal hold counter; must satisfy 2**HOLD_W > MAX_HOLD

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  4  request lines; req[k] = 1 means channel k wants the mux
sel  output  2  index of current owner; drives the mux select
gnt  output  4  one-hot grant; equals (1<<sel) when gnt_valid=1, else 0
gnt_valid  output  1  1 while a channel owns the mux
hold_cnt  output  HOLD_W  cycles the current owner has held the grant, saturating at MAX_HOLD (debug/verification)

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: sel=0, gnt=0, gnt_valid=0, hold_cnt=0, internal last_ptr=3, state=IDLE. Outputs clear immediately on rst_n falling, without waiting for a clock edge. This includes reset mid-grant.
- All outputs are registered. Latency from req rising to gnt is 1 clock edge.
- Rotating priority: search order starts at (last_ptr+1) mod 4 and wraps, e.g. last_ptr=2 gives search order 3,0,1,2. last_ptr updates to the new owner index on every new grant.
- State IDLE:
  - req==0: stay IDLE; outputs unchanged (all zero).
  - Any req bit set: next edge grants the first set bit in rotating order; gnt_valid=1, hold_cnt=1; go to GRANT.
- State GRANT (owner = sel):
  - (a) Release: req[sel]==0.
    - If any other req bit is set, next edge grants the next requester in rotating order directly, with no idle bubble; hold_cnt=1.
    - Otherwise go to IDLE: gnt=0, gnt_valid=0, hold_cnt=0. sel keeps its last value.
  - (b) Hold expiry: req[sel]==1, MAX_HOLD!=0, hold_cnt==MAX_HOLD, and another req bit set. Next edge forces rotation to the next requester; hold_cnt=1.
  - (c) Otherwise keep the owner; hold_cnt increments, saturating at MAX_HOLD. If MAX_HOLD=0, hold_cnt saturates at 2**HOLD_W-1 and rotation happens only on release.
- The rotating search for a new owner always excludes the current owner. If only the owner requests, case (c) applies.
- Simultaneous requests: exactly one grant per edge; gnt is always one-hot or zero.
- Invariant, checked every cycle: gnt_valid == |gnt, and gnt == (gnt_valid ? 1<<sel : 0).
- req bits are sampled only at clock edges. Glitches between edges have no effect.
- Reset released while req is non-zero: the first grant goes to channel 0 if req[0]=1, because last_ptr=3.

Test Plan:
1. Reset and idle: hold rst_n=0 with req=4'hF, then release; on the first edge sel=0, gnt=4'b0001, gnt_valid=1. Assert rst_n=0 mid-cycle and check gnt=0, gnt_valid=0 immediately.
2. Fair rotation: from reset, hold req=4'hF, with each owner dropping its req for 1 cycle after being granted 2 cycles. Required grant sequence: sel=0,1,2,3,0, with no idle cycles between owners.
3. Hold expiry with MAX_HOLD=8: req=4'b0101 held constantly. Owner 0 keeps the grant for exactly 8 cycles (hold_cnt counts 1..8), then sel=2 for 8 cycles, then sel=0. gnt is never zero.
4. Sole requester beyond MAX_HOLD: req=4'b1000 held for 20 cycles. sel=3 throughout; hold_cnt saturates at 8; gnt_valid stays 1.
5. Release to idle: owner 1 only, req drops to 0. Next edge gives gnt_valid=0, gnt=0, sel stays 1. Then req=4'b0011 gives a grant to channel 0, because the search starts after last_ptr=1 (order 2,3,0,1).
6. Mux integration: connect sel to the 4:1 mux with {i3,i2,i1,i0}=4'h5 and req=4'hF rotating as in test 2. y must follow 1,0,1,0 while gnt_valid=1.
